// File: rtl/serial_frame_defs.sv
// Shared definitions for the serial frame transmitter and its matching receiver:
// state encoding, line levels and a counter-width helper.
package serial_frame_defs;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Counter width for a count of n, never below one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts clk cycles within one serial bit and flags the last one.
module bit_timer
  import serial_frame_defs::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = cnt_width(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_end = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, LSB-first data, optional parity, stop bit.
// The line is registered and idles high; done pulses in the first idle cycle.
module serial_frame_tx
  import serial_frame_defs::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              x,
  output logic              busy,
  output logic              done
);

  localparam int BW = cnt_width(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic              x_q, x_d;
  logic              done_q, done_d;
  logic              parity_q, parity_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              bit_end;
  logic              timer_clear;

  // Holding the timer cleared while idle makes every frame start from count 0
  assign timer_clear = (state_q == ST_IDLE) || (state_d != state_q);

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  assign busy     = (state_q != ST_IDLE);
  assign tx_ready = ~busy;
  assign x        = x_q;
  assign done     = done_q;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    done_d    = 1'b0;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        x_d       = LINE_IDLE;
        bit_cnt_d = '0;
        if (tx_valid) begin
          shift_d  = tx_data;
          parity_d = (^tx_data) ^ (PARITY_ODD != 0);
          state_d  = ST_START;
          x_d      = START_LVL;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          x_d       = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
              x_d     = parity_q;
            end else begin
              state_d = ST_STOP;
              x_d     = STOP_LVL;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            x_d       = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          x_d     = STOP_LVL;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          x_d     = LINE_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        x_d     = LINE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      x_q       <= LINE_IDLE;
      done_q    <= 1'b0;
      parity_q  <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      done_q    <= done_d;
      parity_q  <= parity_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: four configurations, directed words with
// hand-written frames pushed on send and checked by per-instance line monitors.
module tb_serial_frame_tx;

  localparam int NDUT = 4;
  localparam int BC   [NDUT] = '{4, 1, 4, 4};
  localparam int PEN  [NDUT] = '{1, 1, 0, 1};
  localparam int PODD [NDUT] = '{0, 0, 0, 1};

  typedef struct {
    int          dut;
    logic [18:0] bits;
    int          nbits;
    int          gap;
    bit          aborted;
  } frame_t;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid_w [NDUT];
  logic       ready_w    [NDUT];
  logic       x_w        [NDUT];
  logic       busy_w     [NDUT];
  logic       done_w     [NDUT];

  frame_t exp_q[$];
  int     check_count = 0;
  int     pass_count  = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    serial_frame_tx #(
      .DATA_W    (8),
      .BIT_CYCLES(BC[g]),
      .PARITY_EN (PEN[g]),
      .PARITY_ODD(PODD[g])
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .tx_data (tx_data),
      .tx_valid(tx_valid_w[g]),
      .tx_ready(ready_w[g]),
      .x       (x_w[g]),
      .busy    (busy_w[g]),
      .done    (done_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [79:0] got, input logic [79:0] want);
    check_count++;
    if (got === want) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic failCheck(input string name);
    check_count++;
    $display("[TB] FAIL %s: bound expired or event missing", name);
  endtask

  task automatic pushFrame(input int dut, input logic [18:0] bits, input int nbits,
                           input int gap, input bit aborted);
    frame_t f;
    f.dut = dut; f.bits = bits; f.nbits = nbits; f.gap = gap; f.aborted = aborted;
    exp_q.push_back(f);
  endtask

  // Presents a word and returns just after the edge that accepted it
  task automatic applyStimulus(input int idx, input logic [7:0] word);
    int n = 0;
    tx_data = word;
    tx_valid_w[idx] = 1'b1;
    while (ready_w[idx] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      failCheck($sformatf("accept_timeout_d%0d", idx));
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDone(input int idx);
    int n = 0;
    while (done_w[idx] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) failCheck($sformatf("done_timeout_d%0d", idx));
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic monitor(input int idx);
    frame_t      e;
    logic [79:0] got;
    logic [79:0] expv;
    int          col = 0;
    int          gap = 0;
    int          span;
    bit          in_frame = 0;
    bit          after_done = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if (in_frame) begin
          checkOutput($sformatf("abort_expected_d%0d", idx), 80'(e.aborted), 80'd1);
          checkOutput($sformatf("abort_no_done_d%0d", idx), 80'(done_w[idx]), 80'd0);
          checkOutput($sformatf("abort_x_d%0d", idx), 80'(x_w[idx]), 80'd1);
        end
        in_frame = 0;
        after_done = 0;
        gap = 0;
      end else begin
        if (after_done) begin
          checkOutput($sformatf("done_width_d%0d", idx), 80'(done_w[idx]), 80'd0);
          after_done = 0;
        end
        if (!in_frame) begin
          if (busy_w[idx] === 1'b1) begin
            if (exp_q.size() == 0) begin
              failCheck($sformatf("unexpected_frame_d%0d", idx));
              e.dut = idx; e.bits = '0; e.nbits = 0; e.gap = -1; e.aborted = 0;
            end else begin
              e = exp_q.pop_front();
              checkOutput($sformatf("frame_owner_d%0d", idx), 80'(idx), 80'(e.dut));
              if (e.gap >= 0)
                checkOutput($sformatf("idle_gap_d%0d", idx), 80'(gap), 80'(e.gap));
            end
            in_frame = 1;
            got = '0;
            got[0] = x_w[idx];
            col = 1;
          end else begin
            gap++;
          end
        end else if (busy_w[idx] === 1'b1) begin
          if (col < 80) got[col] = x_w[idx];
          col++;
        end else begin
          span = e.nbits * BC[idx];
          expv = '0;
          for (int k = 0; k < span && k < 80; k++) expv[k] = e.bits[k / BC[idx]];
          checkOutput($sformatf("not_aborted_d%0d", idx), 80'(e.aborted), 80'd0);
          checkOutput($sformatf("busy_len_d%0d", idx), 80'(col), 80'(span));
          checkOutput($sformatf("frame_bits_d%0d", idx), got, expv);
          checkOutput($sformatf("done_pulse_d%0d", idx), 80'(done_w[idx]), 80'd1);
          checkOutput($sformatf("stop_idle_x_d%0d", idx), 80'(x_w[idx]), 80'd1);
          in_frame = 0;
          after_done = 1;
          gap = 1;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    tx_data = '0;
    for (int i = 0; i < NDUT; i++) tx_valid_w[i] = 1'b0;
    fork
      monitor(0);
      monitor(1);
      monitor(2);
      monitor(3);
    join_none
    #3 rst = 1'b0;
    #9;
    for (int i = 0; i < NDUT; i++)
      checkOutput($sformatf("reset_state_d%0d", i),
                  80'({x_w[i], ready_w[i], busy_w[i], done_w[i]}), 80'(4'b1100));
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++)
        checkOutput($sformatf("idle_d%0d", i),
                    80'({x_w[i], ready_w[i], busy_w[i], done_w[i]}), 80'(4'b1100));
    end

    // Even parity, four cycles per bit
    pushFrame(0, {1'b1, 1'b0, 8'hA5, 1'b0}, 11, -1, 0);
    applyStimulus(0, 8'hA5);
    tx_valid_w[0] = 1'b0;
    waitDone(0);
    pushFrame(0, {1'b1, 1'b1, 8'h13, 1'b0}, 11, -1, 0);
    applyStimulus(0, 8'h13);
    tx_valid_w[0] = 1'b0;
    waitDone(0);

    // Odd parity
    pushFrame(3, {1'b1, 1'b0, 8'h07, 1'b0}, 11, -1, 0);
    applyStimulus(3, 8'h07);
    tx_valid_w[3] = 1'b0;
    waitDone(3);
    pushFrame(3, {1'b1, 1'b1, 8'h03, 1'b0}, 11, -1, 0);
    applyStimulus(3, 8'h03);
    tx_valid_w[3] = 1'b0;
    waitDone(3);

    // No parity slot
    pushFrame(2, {1'b1, 8'h07, 1'b0}, 10, -1, 0);
    applyStimulus(2, 8'h07);
    tx_valid_w[2] = 1'b0;
    waitDone(2);

    // One cycle per bit
    pushFrame(1, {1'b1, 1'b0, 8'hFF, 1'b0}, 11, -1, 0);
    applyStimulus(1, 8'hFF);
    tx_valid_w[1] = 1'b0;
    waitDone(1);
    pushFrame(1, {1'b1, 1'b1, 8'h80, 1'b0}, 11, -1, 0);
    applyStimulus(1, 8'h80);
    tx_valid_w[1] = 1'b0;
    waitDone(1);

    // Back-to-back with tx_valid held and tx_data changed mid-frame
    pushFrame(0, {1'b1, 1'b0, 8'h3C, 1'b0}, 11, -1, 0);
    pushFrame(0, {1'b1, 1'b0, 8'hC3, 1'b0}, 11, 1, 0);
    applyStimulus(0, 8'h3C);
    tx_data = 8'hC3;
    applyStimulus(0, 8'hC3);
    tx_valid_w[0] = 1'b0;
    waitDone(0);

    // Reset in the middle of data bit 3
    pushFrame(0, {1'b1, 1'b0, 8'h5A, 1'b0}, 11, -1, 1);
    applyStimulus(0, 8'h5A);
    tx_valid_w[0] = 1'b0;
    repeat (18) @(posedge clk);
    checkOutput("mid_frame_busy", 80'(busy_w[0]), 80'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_async",
                80'({x_w[0], ready_w[0], busy_w[0], done_w[0]}), 80'(4'b1100));
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    pushFrame(0, {1'b1, 1'b0, 8'h12, 1'b0}, 11, -1, 0);
    applyStimulus(0, 8'h12);
    tx_valid_w[0] = 1'b0;
    waitDone(0);

    repeat (5) @(negedge clk);
    checkOutput("queue_empty", 80'(exp_q.size()), 80'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
